// File: rtl/ysyx_22041412_csr_ctrl.sv
// ysyx_22041412_csr_ctrl
// Execute-stage requester for the machine-CSR unit. Accepts one decoded
// SYSTEM instruction, maps the CSR number to the unit's 3-bit index, runs
// the en/ready request protocol (including the held-enable commit cycle
// for writes) and returns either rd writeback data or a fetch redirect.
module ysyx_22041412_csr_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_pc,
    input  logic [2:0]  in_op,
    input  logic [11:0] in_csr,
    input  logic [63:0] in_rs1,
    input  logic [4:0]  in_zimm,
    input  logic [4:0]  in_rd,
    input  logic        in_ecall,
    input  logic        in_mret,
    input  logic        flush,
    output logic        csr_en,
    output logic [2:0]  csr_addr,
    output logic [2:0]  csr_func3,
    output logic [63:0] csr_wdata,
    output logic [63:0] csr_pc,
    input  logic [63:0] csr_rdata,
    input  logic        csr_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [63:0] out_data,
    output logic        redir_valid,
    output logic [63:0] redir_pc,
    output logic        illegal,
    output logic        timeout
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WR, DONE} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_pc, r_wdata, r_data;
    logic [2:0]  r_op, r_addr;
    logic [4:0]  r_rd;
    logic        r_sys, r_illegal, r_timeout, r_flushed;
    logic [CW-1:0] r_cnt;

    logic        w_accept, w_sys_in, w_hit, w_ill_in, w_last, w_drop, w_ok;
    logic [2:0]  w_map, w_addr_in;

    // Decode the offered instruction: CSR index, legality, unit address.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // can leave it unassigned and infer a latch.
        w_hit = 1'b1;
        w_map = 3'd0;
        case (in_csr)
            12'h300: w_map = 3'd2;
            12'h305: w_map = 3'd3;
            12'h341: w_map = 3'd4;
            12'h342: w_map = 3'd5;
            default: w_hit = 1'b0;
        endcase
        w_sys_in  = (in_op == 3'b000);
        w_ill_in  = (in_op == 3'b100) ||
                    (w_sys_in ? !(in_ecall ^ in_mret) : !w_hit);
        w_addr_in = w_sys_in ? {2'b00, in_ecall} : w_map;
    end

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_cnt == CW'(TIMEOUT - 1));
    // A flush seen anywhere during the protocol discards the result at the end.
    assign w_drop   = r_flushed || flush;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (in_valid) w_next = w_ill_in ? DONE : REQ;
            REQ: begin
                if (csr_ready) begin
                    if (r_op != 3'b000) w_next = WR;
                    else                w_next = w_drop ? IDLE : DONE;
                end else if (w_last) begin
                    w_next = w_drop ? IDLE : DONE;
                end
            end
            WR:      w_next = w_drop ? IDLE : DONE;
            DONE:    if (flush || out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the instruction on accept; capture response, count REQ cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_wdata   <= '0;
            r_data    <= '0;
            r_op      <= '0;
            r_addr    <= '0;
            r_rd      <= '0;
            r_sys     <= 1'b0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_flushed <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_pc      <= in_pc;
            r_wdata   <= in_op[2] ? {59'b0, in_zimm} : in_rs1;
            r_data    <= '0;
            r_op      <= in_op;
            r_addr    <= w_addr_in;
            r_rd      <= in_rd;
            r_sys     <= w_sys_in;
            r_illegal <= w_ill_in;
            r_timeout <= 1'b0;
            r_flushed <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == REQ) begin
            r_cnt <= r_cnt + 1'b1;
            if (flush) r_flushed <= 1'b1;
            if (csr_ready)   r_data    <= csr_rdata;
            else if (w_last) r_timeout <= 1'b1;
        end else if (r_state == WR) begin
            if (flush) r_flushed <= 1'b1;
        end
    end

    // Output decode from state and latched fields.
    always_comb begin
        w_ok        = (r_state == DONE) && !r_illegal && !r_timeout;
        in_ready    = (r_state == IDLE);
        csr_en      = (r_state == REQ) || (r_state == WR);
        csr_addr    = csr_en ? r_addr  : 3'd0;
        csr_func3   = csr_en ? r_op    : 3'd0;
        csr_wdata   = csr_en ? r_wdata : 64'd0;
        csr_pc      = csr_en ? r_pc    : 64'd0;
        out_valid   = (r_state == DONE);
        out_rd      = out_valid ? r_rd : 5'd0;
        out_we      = w_ok && !r_sys && (r_rd != 5'd0);
        out_data    = w_ok ? r_data : 64'd0;
        redir_valid = w_ok && r_sys;
        redir_pc    = redir_valid ? r_data : 64'd0;
        illegal     = out_valid && r_illegal;
        timeout     = out_valid && r_timeout;
    end

endmodule

// File: tb/tb_ysyx_22041412_csr_ctrl.sv
// Testbench for ysyx_22041412_csr_ctrl with a behavioural machine-CSR unit.
module tb_ysyx_22041412_csr_ctrl;

    logic        clk, rst;
    logic        in_valid, in_ready, in_ecall, in_mret, flush;
    logic [63:0] in_pc, in_rs1;
    logic [2:0]  in_op;
    logic [11:0] in_csr;
    logic [4:0]  in_zimm, in_rd;
    logic        csr_en, csr_ready;
    logic [2:0]  csr_addr, csr_func3;
    logic [63:0] csr_wdata, csr_pc, csr_rdata;
    logic        out_valid, out_ready, out_we, redir_valid, illegal, timeout;
    logic [4:0]  out_rd;
    logic [63:0] out_data, redir_pc;

    int checks = 0;
    int failures = 0;

    ysyx_22041412_csr_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_op(in_op),
        .in_csr(in_csr), .in_rs1(in_rs1), .in_zimm(in_zimm), .in_rd(in_rd),
        .in_ecall(in_ecall), .in_mret(in_mret), .flush(flush),
        .csr_en(csr_en), .csr_addr(csr_addr), .csr_func3(csr_func3),
        .csr_wdata(csr_wdata), .csr_pc(csr_pc), .csr_rdata(csr_rdata),
        .csr_ready(csr_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_we(out_we), .out_data(out_data),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .illegal(illegal), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- CSR unit model ----------------
    logic [63:0] u_mstatus, u_mtvec, u_mepc, u_mcause, u_old, u_new;
    logic        u_phase, u_resp_on;

    assign csr_ready = csr_en && !u_phase && u_resp_on;

    always_comb begin
        case (csr_addr)
            3'd0:    u_old = u_mepc;
            3'd1:    u_old = u_mtvec;
            3'd2:    u_old = u_mstatus;
            3'd3:    u_old = u_mtvec;
            3'd4:    u_old = u_mepc;
            3'd5:    u_old = u_mcause;
            default: u_old = 64'd0;
        endcase
        csr_rdata = u_old;
        case (csr_func3[1:0])
            2'b01:   u_new = csr_wdata;
            2'b10:   u_new = u_old | csr_wdata;
            2'b11:   u_new = u_old & ~csr_wdata;
            default: u_new = u_old;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_mstatus <= '0; u_mtvec <= '0; u_mepc <= '0; u_mcause <= '0;
            u_phase   <= 1'b0;
        end else if (!csr_en) begin
            u_phase <= 1'b0;
        end else if (csr_ready) begin
            u_phase <= 1'b1;
            if (csr_addr == 3'd1) begin
                u_mepc   <= csr_pc;
                u_mcause <= 64'd11;
            end
        end else if (u_phase) begin
            case (csr_addr)
                3'd2: u_mstatus <= u_new;
                3'd3: u_mtvec   <= u_new;
                3'd4: u_mepc    <= u_new;
                3'd5: u_mcause  <= u_new;
                default: ;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;   logic [11:0] csr;  logic [63:0] rs1; logic [4:0] zimm;
        logic [4:0]  rd;   logic ecall;       logic mret;       logic [63:0] pc;
        int          en;   int lat;           logic [2:0] addr; logic [63:0] wdata;
        logic        we;   logic chkd;        logic [63:0] data;
        logic        redir; logic [63:0] rpc; logic ill;
    } vec_t;

    function automatic vec_t mk(
        input logic [2:0] op, input logic [11:0] csr, input logic [63:0] rs1,
        input logic [4:0] zimm, input logic [4:0] rd, input logic ec, input logic mr,
        input logic [63:0] pc, input int en, input int lat, input logic [2:0] addr,
        input logic [63:0] wdata, input logic we, input logic chkd, input logic [63:0] data,
        input logic redir, input logic [63:0] rpc, input logic ill);
        vec_t v;
        v.op = op; v.csr = csr; v.rs1 = rs1; v.zimm = zimm; v.rd = rd;
        v.ecall = ec; v.mret = mr; v.pc = pc; v.en = en; v.lat = lat;
        v.addr = addr; v.wdata = wdata; v.we = we; v.chkd = chkd; v.data = data;
        v.redir = redir; v.rpc = rpc; v.ill = ill;
        return v;
    endfunction

    int          lat, en_cnt;
    logic [2:0]  s_addr, s_f3;
    logic [63:0] s_wdata, s_pc;

    // Offer one instruction at a negedge; return at the first negedge with
    // out_valid (or after a bounded wait), recording csr_en activity.
    task automatic issue(input logic [2:0] op, input logic [11:0] csr, input logic [63:0] rs1,
                         input logic [4:0] zimm, input logic [4:0] rd, input logic ec,
                         input logic mr, input logic [63:0] pc, input int limit);
        @(negedge clk);
        in_op = op; in_csr = csr; in_rs1 = rs1; in_zimm = zimm; in_rd = rd;
        in_ecall = ec; in_mret = mr; in_pc = pc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; en_cnt = 0;
        s_addr = '0; s_f3 = '0; s_wdata = '0; s_pc = '0;
        while (!out_valid && lat < limit) begin
            if (csr_en) begin
                if (en_cnt == 0) begin
                    s_addr = csr_addr; s_f3 = csr_func3; s_wdata = csr_wdata; s_pc = csr_pc;
                end
                en_cnt++;
            end
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_wait_expired", 64'(out_valid), 64'd1);
    endtask

    // Handshake the result and confirm the controller is idle afterwards.
    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_ack_out_valid", 64'(out_valid), 64'd0);
        check("idle_after_ack_csr_en", 64'(csr_en), 64'd0);
    endtask

    vec_t vecs[15];
    logic [63:0] h_data;
    int hs, nv;

    initial begin
        rst = 1'b1; in_valid = 0; in_pc = 0; in_op = 0; in_csr = 0; in_rs1 = 0;
        in_zimm = 0; in_rd = 0; in_ecall = 0; in_mret = 0; flush = 0; out_ready = 0;
        u_resp_on = 1'b1;

        //              op      csr     rs1            zimm rd  ec mr pc             en lat addr wdata          we chk data           rd  rpc            ill
        vecs[0]  = mk(3'b001, 12'h305, 64'h8000_0100, 5'd0, 5'd5, 0, 0, 64'h8000_0000, 2, 3, 3'd3, 64'h8000_0100, 1, 1, 64'h0,         0, 64'h0,         0);
        vecs[1]  = mk(3'b000, 12'h000, 64'h0,         5'd0, 5'd0, 1, 0, 64'h8000_0040, 1, 2, 3'd1, 64'h0,         0, 0, 64'h0,         1, 64'h8000_0100, 0);
        vecs[2]  = mk(3'b010, 12'h341, 64'h0,         5'd0, 5'd6, 0, 0, 64'h8000_0044, 2, 3, 3'd4, 64'h0,         1, 1, 64'h8000_0040, 0, 64'h0,         0);
        vecs[3]  = mk(3'b010, 12'h342, 64'h0,         5'd0, 5'd7, 0, 0, 64'h8000_0048, 2, 3, 3'd5, 64'h0,         1, 1, 64'hb,         0, 64'h0,         0);
        vecs[4]  = mk(3'b110, 12'h300, 64'hdead,      5'd8, 5'd0, 0, 0, 64'h8000_004c, 2, 3, 3'd2, 64'h8,         0, 1, 64'h0,         0, 64'h0,         0);
        vecs[5]  = mk(3'b011, 12'h300, 64'h0,         5'd0, 5'd9, 0, 0, 64'h8000_0050, 2, 3, 3'd2, 64'h0,         1, 1, 64'h8,         0, 64'h0,         0);
        vecs[6]  = mk(3'b111, 12'h300, 64'hffff,      5'd8, 5'd10,0, 0, 64'h8000_0054, 2, 3, 3'd2, 64'h8,         1, 1, 64'h8,         0, 64'h0,         0);
        vecs[7]  = mk(3'b101, 12'h300, 64'h0,         5'd3, 5'd11,0, 0, 64'h8000_0058, 2, 3, 3'd2, 64'h3,         1, 1, 64'h0,         0, 64'h0,         0);
        vecs[8]  = mk(3'b001, 12'h341, 64'h8000_0200, 5'd0, 5'd12,0, 0, 64'h8000_005c, 2, 3, 3'd4, 64'h8000_0200, 1, 1, 64'h8000_0040, 0, 64'h0,         0);
        vecs[9]  = mk(3'b000, 12'h000, 64'h0,         5'd0, 5'd0, 0, 1, 64'h8000_0060, 1, 2, 3'd0, 64'h0,         0, 0, 64'h0,         1, 64'h8000_0200, 0);
        vecs[10] = mk(3'b010, 12'hc00, 64'h0,         5'd0, 5'd1, 0, 0, 64'h8000_0064, 0, 1, 3'd0, 64'h0,         0, 1, 64'h0,         0, 64'h0,         1);
        vecs[11] = mk(3'b100, 12'h300, 64'h0,         5'd0, 5'd1, 0, 0, 64'h8000_0068, 0, 1, 3'd0, 64'h0,         0, 1, 64'h0,         0, 64'h0,         1);
        vecs[12] = mk(3'b000, 12'h000, 64'h0,         5'd0, 5'd0, 1, 1, 64'h8000_006c, 0, 1, 3'd0, 64'h0,         0, 1, 64'h0,         0, 64'h0,         1);
        vecs[13] = mk(3'b000, 12'h000, 64'h0,         5'd0, 5'd0, 0, 0, 64'h8000_0070, 0, 1, 3'd0, 64'h0,         0, 1, 64'h0,         0, 64'h0,         1);
        vecs[14] = mk(3'b010, 12'h300, 64'h0,         5'd0, 5'd13,0, 0, 64'h8000_0074, 2, 3, 3'd2, 64'h0,         1, 1, 64'h3,         0, 64'h0,         0);

        // Reset state
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_csr_en", 64'(csr_en), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_we", 64'(out_we), 64'd0);
        check("rst_redir", 64'(redir_valid), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors (in order; unit state carries across)
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].csr, vecs[i].rs1, vecs[i].zimm, vecs[i].rd,
                  vecs[i].ecall, vecs[i].mret, vecs[i].pc, 40);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_en_cycles", i), 64'(en_cnt), 64'(vecs[i].en));
            check($sformatf("v%0d_en_in_done", i), 64'(csr_en), 64'd0);
            if (vecs[i].en > 0) begin
                check($sformatf("v%0d_csr_addr", i), 64'(s_addr), 64'(vecs[i].addr));
                check($sformatf("v%0d_csr_func3", i), 64'(s_f3), 64'(vecs[i].op));
                check($sformatf("v%0d_csr_wdata", i), s_wdata, vecs[i].wdata);
                check($sformatf("v%0d_csr_pc", i), s_pc, vecs[i].pc);
            end
            check($sformatf("v%0d_out_we", i), 64'(out_we), 64'(vecs[i].we));
            if (vecs[i].we) check($sformatf("v%0d_out_rd", i), 64'(out_rd), 64'(vecs[i].rd));
            if (vecs[i].chkd) check($sformatf("v%0d_out_data", i), out_data, vecs[i].data);
            check($sformatf("v%0d_redir_valid", i), 64'(redir_valid), 64'(vecs[i].redir));
            if (vecs[i].redir) check($sformatf("v%0d_redir_pc", i), redir_pc, vecs[i].rpc);
            check($sformatf("v%0d_illegal", i), 64'(illegal), 64'(vecs[i].ill));
            check($sformatf("v%0d_timeout", i), 64'(timeout), 64'd0);
            ack();
        end
        check("unit_mtvec", u_mtvec, 64'h8000_0100);
        check("unit_mepc", u_mepc, 64'h8000_0200);
        check("unit_mcause", u_mcause, 64'hb);
        check("unit_mstatus", u_mstatus, 64'h3);

        // Timeout: unit never responds
        u_resp_on = 1'b0;
        issue(3'b010, 12'h300, 64'h0, 5'd0, 5'd1, 0, 0, 64'h8000_0100, 40);
        u_resp_on = 1'b1;
        check("to_req_cycles", 64'(en_cnt), 64'd16);
        check("to_latency", 64'(lat), 64'd17);
        check("to_timeout", 64'(timeout), 64'd1);
        check("to_csr_en", 64'(csr_en), 64'd0);
        check("to_out_we", 64'(out_we), 64'd0);
        check("to_redir", 64'(redir_valid), 64'd0);
        ack();

        // Flush during WR: write still commits, no result produced
        @(negedge clk);
        in_op = 3'b001; in_csr = 12'h305; in_rs1 = 64'h8000_0300; in_zimm = 0;
        in_rd = 5'd14; in_ecall = 0; in_mret = 0; in_pc = 64'h8000_0104; in_valid = 1'b1;
        @(negedge clk);                      // REQ
        in_valid = 1'b0;
        @(negedge clk);                      // WR
        check("fl_en_in_wr", 64'(csr_en), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_in_ready", 64'(in_ready), 64'd1);
        nv = 0;
        for (int k = 0; k < 4; k++) begin
            nv += int'(out_valid) + int'(csr_en);
            @(negedge clk);
        end
        check("fl_no_valid_no_en", 64'(nv), 64'd0);
        check("fl_unit_mtvec", u_mtvec, 64'h8000_0300);

        // out_ready held low for 3 cycles in DONE: fields stable, one handshake
        issue(3'b010, 12'h305, 64'h0, 5'd0, 5'd15, 0, 0, 64'h8000_0108, 40);
        check("hold_data", out_data, 64'h8000_0300);
        h_data = out_data;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("hold%0d_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d_data", k), out_data, h_data);
            check($sformatf("hold%0d_rd", k), 64'(out_rd), 64'd15);
        end
        out_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 4; k++) begin
            hs += int'(out_valid);
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("hold_handshakes", 64'(hs), 64'd1);

        // flush together with out_ready in DONE: result dropped next cycle
        issue(3'b010, 12'h300, 64'h0, 5'd0, 5'd3, 0, 0, 64'h8000_010c, 40);
        check("fd_data", out_data, 64'h3);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        check("fd_valid_dropped", 64'(out_valid), 64'd0);
        check("fd_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of REQ
        u_resp_on = 1'b0;
        @(negedge clk);
        in_op = 3'b001; in_csr = 12'h300; in_rs1 = 64'h1; in_rd = 5'd1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("ar_en_before", 64'(csr_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_en_cleared", 64'(csr_en), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        u_resp_on = 1'b1;
        @(negedge clk);
        check("ar_idle_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

endmodule
